// File: rtl/regb_fifo_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the register-FIFO write-port arbiter.
package regb_fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p * 2) r++;
        return r;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive
    function automatic int unsigned occ_width(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/regb_fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write-port arbiter.
interface regb_fifo_wr_arbiter_if
    import regb_fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 5
);
    localparam int unsigned CW = occ_width(DEPTH);
    localparam int unsigned OW = idx_width(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      fifo_wdata;
    logic                  fifo_shift_in;
    logic                  fifo_shift_out;
    logic [CW-1:0]         occupancy;
    logic [OW-1:0]         owner;

    modport master (
        output req, req_wdata, fifo_shift_out,
        input  gnt, fifo_wdata, fifo_shift_in, occupancy, owner
    );

    modport slave (
        input  req, req_wdata, fifo_shift_out,
        output gnt, fifo_wdata, fifo_shift_in, occupancy, owner
    );

endinterface

// File: rtl/regb_fifo_wr_arbiter_rr_priority_pick.sv
// Rotating-priority encoder: first set bit of req at or after start, wrapping.
module rr_priority_pick
    import regb_fifo_wr_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic            found,
    output logic [IW-1:0]   idx
);

    // Upper segment [start..NREQ-1] first, then the wrapped segment [0..start-1]
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req[i] && (IW'(i) >= start)) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req[i] && (IW'(i) < start)) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/regb_fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one register-FIFO write port;
// mirrors FIFO occupancy so a push into a full FIFO is never issued.
module regb_fifo_wr_arbiter
    import regb_fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEPTH     = 5,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   res,
    regb_fifo_wr_arbiter_if.slave  bus
);

    localparam int unsigned CW  = occ_width(DEPTH);
    localparam int unsigned CWX = CW + 1;
    localparam int unsigned OW  = idx_width(NREQ);
    localparam int unsigned BW  = clog2(MAX_BURST + 1);

    arb_state_e       state, state_d;
    logic [OW-1:0]    rr_ptr, rr_d;
    logic [OW-1:0]    owner, owner_d;
    logic [BW-1:0]    burst_cnt, cnt_d;
    logic [CW-1:0]    occ_r;
    logic             shift_in_r;
    logic [WIDTH-1:0] wdata_r;

    logic             pop;
    logic [CWX-1:0]   occ_after;
    logic             room;
    logic [OW-1:0]    owner_inc;
    logic [OW-1:0]    pick_start;
    logic             pick_found;
    logic [OW-1:0]    pick_idx;
    logic             do_gnt;
    logic [OW-1:0]    gnt_idx;
    logic [NREQ-1:0]  gnt_vec;
    logic [WIDTH-1:0] sel_data;

    // Fill level after this edge's push/pop; a grant is only legal if it stays below DEPTH
    assign pop       = bus.fifo_shift_out && (occ_r != '0);
    assign occ_after = {1'b0, occ_r} + CWX'(shift_in_r) - CWX'(pop);
    assign room      = occ_after < CWX'(DEPTH);

    assign owner_inc  = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
    assign pick_start = (state == IDLE) ? rr_ptr : owner_inc;

    rr_priority_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Grant decision and next arbitration state
    always_comb begin
        state_d = state;
        rr_d    = rr_ptr;
        owner_d = owner;
        cnt_d   = burst_cnt;
        do_gnt  = 1'b0;
        gnt_idx = owner;

        if (state == IDLE) begin
            if (room && pick_found) begin
                do_gnt  = 1'b1;
                gnt_idx = pick_idx;
                owner_d = pick_idx;
                cnt_d   = BW'(1);
                state_d = BURST;
            end
        end else if (room) begin
            if (bus.req[owner]) begin
                if (burst_cnt < BW'(MAX_BURST)) begin
                    do_gnt = 1'b1;
                    cnt_d  = burst_cnt + BW'(1);
                end else begin
                    // Burst exhausted: owner itself is still a candidate, so pick_found holds
                    rr_d    = owner_inc;
                    do_gnt  = 1'b1;
                    gnt_idx = pick_idx;
                    owner_d = pick_idx;
                    cnt_d   = BW'(1);
                end
            end else begin
                rr_d = owner_inc;
                if (pick_found) begin
                    do_gnt  = 1'b1;
                    gnt_idx = pick_idx;
                    owner_d = pick_idx;
                    cnt_d   = BW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
        end

        if (res) do_gnt = 1'b0;
    end

    // One-hot grant and matching data slice
    always_comb begin
        gnt_vec  = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_idx == OW'(i)) begin
                gnt_vec[i] = do_gnt;
                sel_data   = bus.req_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            burst_cnt  <= '0;
            occ_r      <= '0;
            shift_in_r <= 1'b0;
            wdata_r    <= '0;
        end else begin
            state      <= state_d;
            rr_ptr     <= rr_d;
            owner      <= owner_d;
            burst_cnt  <= cnt_d;
            occ_r      <= CW'(occ_after);
            shift_in_r <= do_gnt;
            if (do_gnt) wdata_r <= sel_data;
        end
    end

    assign bus.gnt           = gnt_vec;
    assign bus.fifo_shift_in = shift_in_r;
    assign bus.fifo_wdata    = wdata_r;
    assign bus.occupancy     = occ_r;
    assign bus.owner         = owner;

    a_occ_bound: assert property (@(posedge clk) disable iff (res) occ_r <= CW'(DEPTH));

endmodule

// File: tb/tb_regb_fifo_wr_arbiter.sv
// Directed self-checking bench for regb_fifo_wr_arbiter.
module tb_regb_fifo_wr_arbiter;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned WIDTH     = 4;
    localparam int unsigned DEPTH     = 5;
    localparam int unsigned MAX_BURST = 4;

    logic clk;
    logic res;
    int   n_tests;
    int   n_fail;

    regb_fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    regb_fifo_wr_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [WIDTH-1:0] d);
        bus.req_wdata[i*WIDTH +: WIDTH] = d;
    endtask

    logic [3:0] t1_data [7] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hE, 4'hE};
    logic [3:0] t1_gnt  [7] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    logic       t1_sin  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] t1_wd   [7] = '{4'h0, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hE};
    logic [2:0] t1_occ  [7] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    int         t2_idx  [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [3:0] t2_word [2]  = '{4'h3, 4'h9};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        res = 1'b1;
        bus.req = 4'b1111;
        bus.req_wdata = '0;
        bus.fifo_shift_out = 1'b0;

        // Reset state, grants suppressed even with all requesters active
        tick();
        tick();
        check("rst_gnt",  32'(bus.gnt), 32'h0);
        check("rst_sin",  32'(bus.fifo_shift_in), 32'h0);
        check("rst_wd",   32'(bus.fifo_wdata), 32'h0);
        check("rst_occ",  32'(bus.occupancy), 32'h0);
        check("rst_own",  32'(bus.owner), 32'h0);

        // Single requester r2 fills the FIFO
        for (int c = 0; c < 7; c++) begin
            tick();
            res = 1'b0;
            bus.req = 4'b0100;
            set_word(2, t1_data[c]);
            #1;
            check($sformatf("t1_gnt_c%0d", c + 1), 32'(bus.gnt), 32'(t1_gnt[c]));
            check($sformatf("t1_sin_c%0d", c + 1), 32'(bus.fifo_shift_in), 32'(t1_sin[c]));
            check($sformatf("t1_wd_c%0d",  c + 1), 32'(bus.fifo_wdata), 32'(t1_wd[c]));
            check($sformatf("t1_occ_c%0d", c + 1), 32'(bus.occupancy), 32'(t1_occ[c]));
        end

        // Full FIFO with simultaneous pop still grants r1
        tick();
        bus.req = 4'b0010;
        set_word(1, 4'h7);
        bus.fifo_shift_out = 1'b1;
        #1;
        check("full_pop_gnt", 32'(bus.gnt), 32'h2);
        check("full_pop_occ", 32'(bus.occupancy), 32'd5);
        tick();
        bus.req = 4'b0000;
        bus.fifo_shift_out = 1'b0;
        #1;
        check("full_pop_occ1", 32'(bus.occupancy), 32'd4);
        check("full_pop_sin",  32'(bus.fifo_shift_in), 32'h1);
        check("full_pop_wd",   32'(bus.fifo_wdata), 32'h7);
        check("full_pop_own",  32'(bus.owner), 32'd1);
        tick();
        bus.fifo_shift_out = 1'b1;
        #1;
        check("full_pop_occ2", 32'(bus.occupancy), 32'd5);
        check("drain_gnt",     32'(bus.gnt), 32'h0);

        // Drain to empty, then one extra pop on an empty FIFO
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            check($sformatf("drain_occ_%0d", k), 32'(bus.occupancy), 32'(4 - k));
        end
        tick();
        #1;
        check("empty_pop_occ", 32'(bus.occupancy), 32'd0);
        check("empty_pop_gnt", 32'(bus.gnt), 32'h0);

        // Burst rotation between r0 and r1 with continuous pops
        for (int k = 0; k < 12; k++) begin
            tick();
            bus.req = 4'b0011;
            set_word(0, t2_word[0]);
            set_word(1, t2_word[1]);
            #1;
            check($sformatf("rot_gnt_%0d", k + 1), 32'(bus.gnt), 32'(1) << t2_idx[k]);
            check($sformatf("rot_occ_%0d", k + 1), 32'(bus.occupancy), (k < 2) ? 32'd0 : 32'd1);
            if (k > 0) begin
                check($sformatf("rot_own_%0d", k + 1), 32'(bus.owner), 32'(t2_idx[k-1]));
                check($sformatf("rot_wd_%0d",  k + 1), 32'(bus.fifo_wdata), 32'(t2_word[t2_idx[k-1]]));
                check($sformatf("rot_sin_%0d", k + 1), 32'(bus.fifo_shift_in), 32'h1);
            end
        end

        // Owner r3 drops its request mid-burst while r0 is waiting
        tick();
        bus.req = 4'b1000;
        set_word(3, 4'h5);
        bus.fifo_shift_out = 1'b0;
        #1;
        check("drop_b1_gnt", 32'(bus.gnt), 32'h8);
        check("drop_b1_own", 32'(bus.owner), 32'd0);
        check("drop_b1_occ", 32'(bus.occupancy), 32'd1);
        tick();
        #1;
        check("drop_b2_gnt", 32'(bus.gnt), 32'h8);
        check("drop_b2_own", 32'(bus.owner), 32'd3);
        check("drop_b2_occ", 32'(bus.occupancy), 32'd2);
        tick();
        bus.req = 4'b0001;
        set_word(0, 4'h6);
        bus.fifo_shift_out = 1'b1;
        #1;
        check("drop_b3_own", 32'(bus.owner), 32'd3);
        check("drop_b3_gnt", 32'(bus.gnt), 32'h1);
        check("drop_b3_occ", 32'(bus.occupancy), 32'd3);
        tick();
        bus.fifo_shift_out = 1'b0;
        #1;
        check("drop_b4_own", 32'(bus.owner), 32'd0);
        check("drop_b4_rr",  32'(dut.rr_ptr), 32'd0);
        check("drop_b4_cnt", 32'(dut.burst_cnt), 32'd1);
        check("drop_b4_occ", 32'(bus.occupancy), 32'd3);
        check("drop_b4_sin", 32'(bus.fifo_shift_in), 32'h1);
        check("drop_b4_wd",  32'(bus.fifo_wdata), 32'h6);
        check("drop_b4_gnt", 32'(bus.gnt), 32'h1);

        // Asynchronous reset between edges, mid-burst
        #2;
        res = 1'b1;
        #1;
        check("arst_gnt", 32'(bus.gnt), 32'h0);
        check("arst_sin", 32'(bus.fifo_shift_in), 32'h0);
        check("arst_occ", 32'(bus.occupancy), 32'd0);
        check("arst_own", 32'(bus.owner), 32'd0);
        check("arst_wd",  32'(bus.fifo_wdata), 32'h0);
        tick();
        res = 1'b0;
        bus.req = 4'b0100;
        set_word(2, 4'h8);
        #1;
        check("post_rst_gnt", 32'(bus.gnt), 32'h4);
        tick();
        bus.req = 4'b0000;
        #1;
        check("post_rst_sin", 32'(bus.fifo_shift_in), 32'h1);
        check("post_rst_wd",  32'(bus.fifo_wdata), 32'h8);
        check("post_rst_own", 32'(bus.owner), 32'd2);
        check("post_rst_gnt0", 32'(bus.gnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regb_fifo_wr_arbiter.md
Name: regb_fifo_wr_arbiter

Overview:
- Shares the single write port of one register-based FIFO (depth DEPTH, width WIDTH) between NREQ producers.
- Arbitration is round-robin with a burst lock: a winner keeps the port for up to MAX_BURST consecutive words.
- Drives the FIFO's shift_in/wdata from registers and mirrors FIFO occupancy internally, so an illegal shift into a full FIFO is never issued.
- Sits directly in front of the FIFO; the consumer's shift_out is also routed into this block for occupancy tracking.

Parameters:
- NREQ, 4, number of requesters (2..16)
- WIDTH, 4, data word width; must equal the FIFO WIDTH
- DEPTH, 5, FIFO depth; must equal the FIFO N
- MAX_BURST, 4, max consecutive grants to one owner before forced rotation (>=1)
- CW, derived ceil(log2(DEPTH+1)), occupancy counter width (localparam)

Ports:
- clk  in  1  clock, all state on rising edge
- res  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester write request; data valid while high
- req_wdata  in  NREQ*WIDTH  flat data; slice i = bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot-or-zero, combinational; gnt[i]=1 means the word is consumed at this edge
- fifo_wdata  out  WIDTH  registered data to FIFO wdata
- fifo_shift_in  out  1  registered, to FIFO shift_in
- fifo_shift_out  in  1  consumer pop request, same signal the FIFO sees
- occupancy  out  CW  mirrored FIFO fill level, registered
- owner  out  log2(NREQ)  current burst owner index (valid in BURST)

Behaviour:
- Reset (async, res=1): state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, occupancy=0, fifo_shift_in=0, fifo_wdata=0. gnt=0 while res=1.
- pop = fifo_shift_out & (occupancy != 0); pops on an empty FIFO are ignored.
- room = (occupancy + fifo_shift_in - pop) < DEPTH, evaluated in the current cycle.
- Occupancy update each edge: occupancy <= occupancy + fifo_shift_in - pop. A simultaneous push and pop leaves it unchanged. It never exceeds DEPTH; a value above DEPTH is an assertion failure.
- Grant latency: gnt[i] in cycle t -> fifo_shift_in=1 with fifo_wdata=req_wdata[i] during cycle t+1 -> the FIFO stores the word at edge t+2. At most one grant per cycle, so sustained throughput is 1 word/cycle when room holds.
- A requester whose gnt was 0 must hold req and data stable. Dropping req without a grant is permitted and loses nothing.
- fifo_shift_in <= |gnt; fifo_wdata updates only when |gnt, otherwise holds.
- IDLE:
  - if room and any req: pick the first requester at or after rr_ptr cyclically; grant it; owner <= pick; burst_cnt <= 1; go to BURST.
  - else stay in IDLE.
- BURST:
  - !room: no grant; hold owner, burst_cnt and state.
  - req[owner] and burst_cnt < MAX_BURST: grant owner; burst_cnt++.
  - req[owner] and burst_cnt == MAX_BURST: rotate. rr_ptr <= owner+1 (mod NREQ); pick from owner+1 cyclically in the same cycle, which may be owner again if it is the sole requester; grant; burst_cnt <= 1.
  - !req[owner]: rr_ptr <= owner+1. If another req, pick from owner+1 and grant with burst_cnt <= 1; otherwise go to IDLE with no grant.
- Full boundary: at occupancy=DEPTH with no pop, gnt stays 0. A pop in the same cycle frees room, so a grant is allowed that cycle.
- Mid-operation reset: everything clears instantly. A word granted but not yet shifted is dropped. The FIFO must be reset by the same event.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=1'b0, BURST=1'b1)
  - a clog2 constant function
  - the sizing rule for CW and owner width
- One sub-module, rr_priority_pick (NREQ parameter):
  - combinational rotate-priority encoder
  - inputs: req vector, start index
  - outputs: found flag, index
  - used for both the IDLE and BURST rotation picks.

Test Plan:
- Single requester: req[2]=1 with data 4'hA, 4'hB, 4'hC, 4'hD, 4'hE; no pops -> gnt[2] in cycles 1..5, fifo_shift_in in cycles 2..6; occupancy reaches 5; gnt=0 afterwards while req is held.
- Burst rotation: req=4'b0011, MAX_BURST=4, consumer pops every cycle -> gnt sequence r0 x4, r1 x4, r0 x4; owner changes 0->1->0; no idle cycle between bursts.
- Full with simultaneous pop: occupancy=5, req[1]=1, fifo_shift_out=1 for one cycle -> gnt[1]=1 that cycle; occupancy stays 5; no assertion.
- Owner drops req mid-burst: r3 holds burst_cnt=2, then drops req while req[0]=1 -> gnt[0] in the same cycle, rr_ptr=0 (wrap from 3), burst_cnt=1.
- Empty pop: occupancy=0, fifo_shift_out=1 -> occupancy stays 0; no underflow.
- Async reset mid-burst: assert res between edges with occupancy=3 -> gnt, fifo_shift_in and occupancy are 0 immediately. After release, req[2] is granted first because rr_ptr=0 and only r2 is requesting.
